// File: rtl/instr_encoder.sv
// instr_encoder: turns structured instruction requests into 32-bit MIPS words
// and streams them into instruction memory, starting at word address 0.
// Only the subset understood by the control decoder is accepted; anything else
// aborts the load with an error code.
//
// Handshakes:
//   request side : a request transfers on a rising edge where in_valid && in_ready.
//   memory side  : a write transfers on a rising edge where mem_we && mem_ready;
//                  mem_addr/mem_wdata are held stable while mem_we is high.
module instr_encoder #(
  parameter int AW = 8,
  parameter int W  = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_opcode,
  input  logic [W-1:0]  in_funct,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_shamt,
  input  logic [15:0]   in_imm,
  input  logic          in_last,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [AW:0]   count,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_OPCODE = 2'd1;
  localparam logic [1:0] ERR_FUNCT  = 2'd2;
  localparam logic [1:0] ERR_OVF    = 2'd3;

  state_t        state_q, state_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    err_code_q, err_code_d;

  logic          bad_opcode;
  logic          bad_funct;
  logic          full;
  logic          accept;
  logic          wr_hs;
  logic [31:0]   enc_word;
  logic [AW+1:0] occupied;

  // Encode the request and classify it against the supported subset.
  always_comb begin
    enc_word   = {in_opcode, in_rs, in_rt, in_imm};
    bad_opcode = 1'b1;
    bad_funct  = 1'b0;
    if (in_opcode == W'(0)) begin
      enc_word   = {in_opcode, in_rs, in_rt, in_rd, in_shamt, in_funct};
      bad_opcode = 1'b0;
      case (in_funct)
        W'(6'h20), W'(6'h21), W'(6'h22), W'(6'h23),
        W'(6'h24), W'(6'h25), W'(6'h27), W'(6'h2A),
        W'(6'h29): bad_funct = 1'b0;
        default:   bad_funct = 1'b1;
      endcase
    end else begin
      case (in_opcode)
        W'(6'h08), W'(6'h0C), W'(6'h0D), W'(6'h0E),
        W'(6'h0A), W'(6'h09), W'(6'h23), W'(6'h2B): bad_opcode = 1'b0;
        default:                                    bad_opcode = 1'b1;
      endcase
    end
    // Words already written plus the one waiting in the output register.
    occupied = {1'b0, count_q} + (AW+2)'(mem_we_q);
    full     = (occupied == ((AW+2)'(1) << AW));
  end

  // Next-state, write-port and status computation.
  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    count_d     = count_q;
    err_code_d  = err_code_q;
    in_ready    = (state_q == S_RUN) && (!mem_we_q || mem_ready);
    accept      = in_valid && in_ready;
    wr_hs       = mem_we_q && mem_ready;

    // A pending write retires in any state, including ERR.
    if (wr_hs) begin
      mem_we_d   = 1'b0;
      mem_addr_d = mem_addr_q + 1'b1;
      count_d    = count_q + 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_RUN;
          mem_we_d   = 1'b0;
          mem_addr_d = '0;
          count_d    = '0;
          err_code_d = ERR_NONE;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (bad_opcode) begin
            state_d    = S_ERR;
            err_code_d = ERR_OPCODE;
          end else if (bad_funct) begin
            state_d    = S_ERR;
            err_code_d = ERR_FUNCT;
          end else if (full) begin
            state_d    = S_ERR;
            err_code_d = ERR_OVF;
          end else begin
            mem_we_d    = 1'b1;
            mem_wdata_d = enc_word;
            if (in_last) state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (wr_hs) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      count_q     <= '0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      count_q     <= count_d;
      err_code_q  <= err_code_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;
  assign err_code  = err_code_q;
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);
  assign dbg_state = state_q;

endmodule
